// File: rtl/satd_block_engine.sv
// rtl/satd_block_engine.sv - BLKxBLK Hadamard SATD engine with row-beat input and valid/ready result.
// Optional build macro SATD_NORM_EN rounds the raw sum down by 2^(LG-1).
module satd_block_engine #(
  parameter int PIX_W = 8,
  parameter int BLK   = 4,
  localparam int LG     = (BLK == 8) ? 3 : 2,
  localparam int SATD_W = PIX_W + 4 * LG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLK*PIX_W-1:0]   ORG,
  input  logic [BLK*PIX_W-1:0]   CUR,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SATD_W-1:0]      satd
);

  localparam int HW = PIX_W + 1 + LG;
  localparam int VW = PIX_W + 1 + 2 * LG;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SUM  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]              r_state;
  logic [LG-1:0]           r_cnt;
  logic [SATD_W-1:0]       r_satd;
  logic signed [HW-1:0]    r_rows [BLK][BLK];

  logic                    w_accept;
  logic signed [HW-1:0]    w_hs [LG+1][BLK];
  logic signed [VW-1:0]    w_vs [LG+1][BLK][BLK];
  logic [SATD_W-1:0]       w_raw;
  logic [SATD_W-1:0]       w_res;

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_DONE);
  assign satd      = r_satd;
  assign w_accept  = in_valid && in_ready;

  // Horizontal butterfly: each stage widens nothing; HW already covers the final growth.
  always_comb begin
    logic [PIX_W:0] d;
    d = '0;
    for (int j = 0; j < BLK; j++) begin
      d = {1'b0, ORG[j*PIX_W +: PIX_W]} - {1'b0, CUR[j*PIX_W +: PIX_W]};
      w_hs[0][j] = {{LG{d[PIX_W]}}, d};
    end
    for (int s = 0; s < LG; s++) begin
      for (int i = 0; i < BLK; i++) begin
        if ((i & (1 << s)) == 0)
          w_hs[s+1][i] = w_hs[s][i] + w_hs[s][i + (1 << s)];
        else
          w_hs[s+1][i] = w_hs[s][i - (1 << s)] - w_hs[s][i];
      end
    end
  end

  // Vertical butterfly per column over the stored rows, then absolute sum.
  always_comb begin
    logic [VW-1:0] mag;
    mag   = '0;
    w_raw = '0;
    for (int r = 0; r < BLK; r++) begin
      for (int c = 0; c < BLK; c++) begin
        w_vs[0][r][c] = {{LG{r_rows[r][c][HW-1]}}, r_rows[r][c]};
      end
    end
    for (int s = 0; s < LG; s++) begin
      for (int i = 0; i < BLK; i++) begin
        for (int c = 0; c < BLK; c++) begin
          if ((i & (1 << s)) == 0)
            w_vs[s+1][i][c] = w_vs[s][i][c] + w_vs[s][i + (1 << s)][c];
          else
            w_vs[s+1][i][c] = w_vs[s][i - (1 << s)][c] - w_vs[s][i][c];
        end
      end
    end
    for (int i = 0; i < BLK; i++) begin
      for (int c = 0; c < BLK; c++) begin
        mag = w_vs[LG][i][c];
        if (mag[VW-1])
          mag = -mag;
        w_raw = w_raw + {{(SATD_W-VW){1'b0}}, mag};
      end
    end
  end

`ifdef SATD_NORM_EN
  localparam int S = LG - 1;
  logic [SATD_W:0] w_rnd;
  assign w_rnd = {1'b0, w_raw} + ((SATD_W+1)'(1) << (S - 1));
  assign w_res = SATD_W'(w_rnd >> S);
`else
  assign w_res = w_raw;
`endif

  // Row buffer carries no reset: every block rewrites all slots before SUM reads them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < BLK; j++)
        r_rows[r_cnt][j] <= w_hs[LG][j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
      r_satd  <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (r_cnt == LG'(BLK - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_SUM;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_SUM: begin
          r_satd  <= w_res;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready)
            r_state <= ST_LOAD;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_satd_block_engine.sv
// tb/tb_satd_block_engine.sv - directed table-driven bench for satd_block_engine (BLK=4 and BLK=8).
module tb_satd_block_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        v4 = 1'b0, rdy4, ov4, ordy4 = 1'b1;
  logic [31:0] org4 = '0, cur4 = '0;
  logic [15:0] satd4;

  logic        v8 = 1'b0, rdy8, ov8, ordy8 = 1'b1;
  logic [63:0] org8 = '0, cur8 = '0;
  logic [19:0] satd8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_prev = 0;
  int t_now = 0;

  typedef struct {
    logic [7:0] org;
    logic [7:0] cur;
    logic [7:0] org00;
    logic [7:0] rs;
    logic [7:0] cs;
    int         raw;
  } vec_t;

  vec_t tab [10];

  satd_block_engine #(.PIX_W(8), .BLK(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .ORG(org4), .CUR(cur4),
    .out_valid(ov4), .out_ready(ordy4), .satd(satd4)
  );

  satd_block_engine #(.PIX_W(8), .BLK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .ORG(org8), .CUR(cur8),
    .out_valid(ov8), .out_ready(ordy8), .satd(satd8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp4(input int raw);
`ifdef SATD_NORM_EN
    return (raw + 1) >> 1;
`else
    return raw;
`endif
  endfunction

  function automatic int exp8(input int raw);
`ifdef SATD_NORM_EN
    return (raw + 2) >> 2;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Caller sits just after a negedge; returns just after the negedge following acceptance.
  task automatic row4(input logic [31:0] o, input logic [31:0] c);
    int n;
    n = 0;
    v4 = 1'b1; org4 = o; cur4 = c;
    while (!rdy4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready4_wait", rdy4, 1);
    @(negedge clk);
  endtask

  task automatic block4(input vec_t t, input bit gaps);
    logic [31:0] o;
    logic [7:0]  p;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        p = 8'(t.org + r * t.rs + j * t.cs);
        if (r == 0 && j == 0) p = t.org00;
        o[j*8 +: 8] = p;
      end
      row4(o, {4{t.cur}});
      if (gaps && r < 3) begin
        v4 = 1'b0;
        @(negedge clk);
      end
    end
    v4 = 1'b0;
  endtask

  task automatic result4(input string nm, input int expv);
    check({nm, "_sum_state"}, ov4, 0);
    @(negedge clk);
    check({nm, "_valid"}, ov4, 1);
    check(nm, satd4, expv);
    t_now = cyc;
  endtask

  task automatic block8(input logic [7:0] o, input logic [7:0] c, input string nm, input int expv);
    int n;
    for (int r = 0; r < 8; r++) begin
      n = 0;
      v8 = 1'b1; org8 = {8{o}}; cur8 = {8{c}};
      while (!rdy8 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("in_ready8_wait", rdy8, 1);
      @(negedge clk);
    end
    v8 = 1'b0;
    check({nm, "_sum_state"}, ov8, 0);
    @(negedge clk);
    check({nm, "_valid"}, ov8, 1);
    check(nm, satd8, expv);
  endtask

  initial begin
    vec_t t;
    int   held;

    tab[0] = '{8'h37, 8'h37, 8'h37, 8'd0, 8'd0, 0};
    tab[1] = '{8'd10, 8'd0,  8'd10, 8'd0, 8'd0, 160};
    tab[2] = '{8'd0,  8'd10, 8'd0,  8'd0, 8'd0, 160};
    tab[3] = '{8'h40, 8'h40, 8'h41, 8'd0, 8'd0, 16};
    tab[4] = '{8'h20, 8'h20, 8'h1F, 8'd0, 8'd0, 16};
    tab[5] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 4080};
    tab[6] = '{8'd0, 8'd255, 8'd0,  8'd0, 8'd0, 4080};
    tab[7] = '{8'd10, 8'd10, 8'd10, 8'd1, 8'd0, 48};
    tab[8] = '{8'd10, 8'd10, 8'd10, 8'd0, 8'd1, 48};
    tab[9] = '{8'd10, 8'd10, 8'd10, 8'd1, 8'd1, 96};

    #12;
    check("rst_out_valid4", ov4, 0);
    check("rst_satd4", satd4, 0);
    check("rst_out_valid8", ov8, 0);
    check("rst_satd8", satd8, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready4", rdy4, 1);

    // Back-to-back blocks with out_ready high: results BLK+2 cycles apart.
    for (int i = 0; i < 10; i++) begin
      block4(tab[i], 1'b0);
      result4($sformatf("vec%0d", i), exp4(tab[i].raw));
      if (i > 0) check($sformatf("period%0d", i), t_now - t_prev, 6);
      t_prev = t_now;
    end

    block8(8'd1, 8'd0, "blk8_diff1", exp8(64));
    block8(8'd255, 8'd0, "blk8_max", exp8(16320));

    // Gapped input, stalled consumer, junk rows offered while DONE.
    ordy4 = 1'b0;
    t = '{8'd5, 8'd2, 8'd5, 8'd0, 8'd0, 48};
    block4(t, 1'b1);
    result4("gapped", exp4(48));
    held = exp4(48);
    v4 = 1'b1; org4 = 32'hFFFF_FFFF; cur4 = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", ov4, 1);
      check("hold_satd", satd4, held);
      check("hold_in_ready", rdy4, 0);
    end
    ordy4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    check("drop_valid", ov4, 0);
    check("drop_in_ready", rdy4, 1);
    block4(tab[1], 1'b0);
    result4("after_hold", exp4(160));

    // Asynchronous reset mid-block discards the partial rows.
    t = '{8'd5, 8'd0, 8'd5, 8'd0, 8'd0, 0};
    row4({4{8'd5}}, {4{8'd0}});
    row4({4{8'd5}}, {4{8'd0}});
    v4 = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_satd", satd4, 0);
    check("async_rst_valid", ov4, 0);
    @(negedge clk);
    rst = 1'b1;
    t = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 16};
    block4(t, 1'b0);
    result4("post_reset", exp4(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/satd_block_engine.md
# satd_block_engine

Parametrised SATD cost engine for the motion-estimation datapath. It takes one row of original (ORG) and candidate (CUR) pixels per accepted beat and forms signed differences. It applies a 2-D Hadamard transform over a BLK×BLK block and returns the sum of absolute transformed coefficients through a valid/ready handshake. It supersedes the single-row difference block, adding block depth, transform, accumulation and flow control.

## Interface
- PIX_W, 8, pixel bit depth (unsigned samples)
- BLK, 4, block edge in pixels; legal values 4 or 8
- localparam LG = log2(BLK); SATD_W = PIX_W + 4*LG (16 for defaults)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  row beat valid
- in_ready  out  1  engine accepts a row this cycle
- ORG  in  BLK*PIX_W  original row; pixel j at [j*PIX_W +: PIX_W]
- CUR  in  BLK*PIX_W  candidate row, same packing
- out_valid  out  1  satd holds a finished block result
- out_ready  in  1  consumer takes result
- satd  out  SATD_W  block SATD, unsigned

## Operation
- FSM states: LOAD, SUM, DONE. Reset state LOAD, row counter 0.
- LOAD: in_ready=1. On in_valid&&in_ready: d[j] = ORG[j] − CUR[j], signed, PIX_W+1 bits. Apply BLK-point horizontal Hadamard (Sylvester, unnormalised, butterfly), width PIX_W+1+LG. Store into row buffer slot = counter, then counter++. On the accept with counter==BLK−1: counter→0, state→SUM.
- SUM: in_ready=0. Apply vertical BLK-point Hadamard per column (width PIX_W+1+2*LG) and take |x| of all BLK² coefficients. Sum them at full SATD_W width, with no saturation needed. Register the result into satd. State→DONE.
- DONE: out_valid=1, satd stable. On out_ready: state→LOAD. in_ready stays 0 during the handshake cycle, so no overlap.
- Coefficient order is irrelevant; only the absolute sum is specified.
- in_valid outside LOAD is ignored, and ORG/CUR are not sampled.
- Row buffer content is not cleared between blocks. Each block fully overwrites all BLK slots.

## Timing
- Reset (rst low, any time, asynchronous): state=LOAD, counter=0, out_valid=0, satd=0, in_ready=1 after release. A partially loaded block is discarded, and the next accepted row is row 0.
- Last row accepted at edge k: SUM during cycle k→k+1. satd and out_valid=1 are visible after edge k+1.
- Minimum block period is BLK+2 cycles with out_ready tied high: BLK load cycles, SUM, DONE.
- out_valid holds with satd constant until out_ready is sampled high. out_valid drops at the following edge.
- Gaps in in_valid stall loading without losing counter state.

## Configuration
- SATD_NORM_EN defined: satd = (raw + (1<<(S−1))) >> S, with S = LG−1. That is (raw+1)>>1 for BLK=4 and (raw+2)>>2 for BLK=8. Normalisation is applied in SUM before the register, and the width stays SATD_W.
- Not defined: satd = raw sum.

## Test plan
- BLK=4: ORG==CUR for all 4 rows (e.g. 0x37 everywhere) -> satd=0, out_valid one edge after SUM.
- BLK=4: ORG=10, CUR=0 everywhere -> raw 160; 80 with SATD_NORM_EN. Swap ORG/CUR -> same value (sign-independence).
- BLK=4: all equal except row0 pixel0 ORG−CUR=1 -> raw 16 (all coefficients ±1); norm 8.
- BLK=4 extreme: ORG=255, CUR=0 -> raw 4080, fits 16 bits. BLK=8, PIX_W=8, diff=1 everywhere -> raw 64, norm 16.
- Handshake: in_valid toggled 1/0 across rows, out_ready low 5 cycles in DONE -> satd/out_valid stable, in_ready=0 throughout. After out_ready, the next block is accepted, giving BLK+2-cycle throughput with out_ready high.
- Reset mid-block: load 2 rows of diff=5, pulse rst low asynchronously between edges, then 4 rows of diff=1 -> satd raw 16 (BLK=4). out_valid=0 and satd=0 immediately on rst assertion.
